// File: rtl/request_encoder_pkg.sv
// Shared types and helpers for the request encoder and its round-robin selector.
package request_encoder_pkg;

    localparam int unsigned N_LINES_DEF = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Ceiling log2, used to size the encoded address.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/request_encoder_if.sv
// Request/address handshake bundle between event sources, encoder and address consumer.
interface request_encoder_if
    import request_encoder_pkg::*;
#(
    parameter int unsigned N_LINES = N_LINES_DEF
);
    localparam int unsigned ADDR_W = clog2(N_LINES);

    logic               enable;
    logic [N_LINES-1:0] req;
    logic               out_ready;
    logic               collision_clr;
    logic [ADDR_W-1:0]  address;
    logic               valid;
    logic [N_LINES-1:0] pending;
    logic [N_LINES-1:0] collision;

    modport master (
        output enable, req, out_ready, collision_clr,
        input  address, valid, pending, collision
    );

    modport slave (
        input  enable, req, out_ready, collision_clr,
        output address, valid, pending, collision
    );

endinterface

// File: rtl/request_encoder_rr_priority_select.sv
// Round-robin priority search: first set bit of pending at or above pointer, wrapping.
module rr_priority_select
    import request_encoder_pkg::*;
#(
    parameter int unsigned N_LINES = N_LINES_DEF,
    parameter int unsigned ADDR_W  = clog2(N_LINES)
) (
    input  logic [N_LINES-1:0] pending,
    input  logic [ADDR_W-1:0]  pointer,
    output logic [ADDR_W-1:0]  index,
    output logic               found
);

    logic [ADDR_W-1:0] idx;

    // Index arithmetic wraps naturally because N_LINES is a power of two.
    always_comb begin
        index = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N_LINES; k++) begin
            idx = pointer + ADDR_W'(k);
            if (!found && pending[idx]) begin
                index = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/request_encoder.sv
// Captures one-hot request lines into a sticky pending set and presents them one at a
// time as a binary address, round-robin, over a valid/ready handshake.
module request_encoder
    import request_encoder_pkg::*;
#(
    parameter int unsigned N_LINES = N_LINES_DEF
) (
    input logic             clk,
    input logic             reset_n,
    request_encoder_if.slave bus
);

    localparam int unsigned ADDR_W = clog2(N_LINES);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic               valid_q, valid_d;
    logic [N_LINES-1:0] pend_q, pend_d;
    logic [N_LINES-1:0] coll_q, coll_d;

    logic               handshake;
    logic [N_LINES-1:0] grant;
    logic [N_LINES-1:0] captured;
    logic [N_LINES-1:0] sel_pending;
    logic [ADDR_W-1:0]  sel_ptr;
    logic [ADDR_W-1:0]  sel_index;
    logic               sel_found;

    assign handshake = (state_q == PRESENT) && bus.out_ready;
    assign captured  = bus.enable ? bus.req : '0;

    always_comb begin
        grant = '0;
        if (handshake) begin
            grant[addr_q] = 1'b1;
        end
    end

    // While presenting, look ahead past the current grant; while idle, search from the pointer.
    assign sel_pending = (state_q == PRESENT) ? (pend_q & ~grant) : pend_q;
    assign sel_ptr     = (state_q == PRESENT) ? (addr_q + ADDR_W'(1)) : ptr_q;

    rr_priority_select #(
        .N_LINES (N_LINES),
        .ADDR_W  (ADDR_W)
    ) u_select (
        .pending (sel_pending),
        .pointer (sel_ptr),
        .index   (sel_index),
        .found   (sel_found)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|pend_q) state_d = PRESENT;
            PRESENT: if (handshake && !sel_found) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A request landing on the line being granted is a fresh event, not a collision.
    always_comb begin
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        pend_d  = (pend_q & ~grant) | captured;
        coll_d  = (bus.collision_clr ? '0 : coll_q) | (captured & pend_q & ~grant);
        valid_d = (state_d == PRESENT);
        if (state_q == IDLE && (|pend_q)) begin
            addr_d = sel_index;
        end
        if (handshake) begin
            ptr_d = addr_q + ADDR_W'(1);
            if (sel_found) begin
                addr_d = sel_index;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            pend_q  <= '0;
            coll_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            coll_q  <= coll_d;
        end
    end

    assign bus.address   = addr_q;
    assign bus.valid     = valid_q;
    assign bus.pending   = pend_q;
    assign bus.collision = coll_q;

endmodule

// File: tb/tb_request_encoder.sv
// Self-checking bench for request_encoder: vector table, hand sequences, random vs. model.
module tb_request_encoder;

    localparam int unsigned N = 4;

    logic clk;
    logic reset_n;

    request_encoder_if #(.N_LINES(N)) bus();

    request_encoder #(.N_LINES(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic       rdy;
        logic       clr;
        logic       v;
        logic [1:0] a;
        logic [3:0] pend;
        logic [3:0] coll;
    } vec_t;

    vec_t tbl [22];

    // Reference model state, kept as plain integers/arrays.
    int m_pend [N];
    int m_coll [N];
    int m_ptr;
    int m_valid;
    int m_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] req, input logic rdy, input logic clr);
        bus.enable        = en;
        bus.req           = req;
        bus.out_ready     = rdy;
        bus.collision_clr = clr;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
    endtask

    function automatic int search(input int bits [N], input int from);
        for (int k = 0; k < N; k++) begin
            if (bits[(from + k) % N] != 0) return (from + k) % N;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_edge(input logic en, input logic [3:0] req, input logic rdy, input logic clr);
        int hs;
        int np [N];
        int nc [N];
        int rem [N];
        int s;
        hs = (m_valid != 0 && rdy) ? 1 : 0;
        for (int i = 0; i < N; i++) begin
            int cleared;
            int newreq;
            cleared = (hs != 0 && i == m_addr) ? 1 : 0;
            newreq  = (en && req[i]) ? 1 : 0;
            np[i]   = ((m_pend[i] != 0 && cleared == 0) || newreq != 0) ? 1 : 0;
            nc[i]   = ((m_coll[i] != 0 && !clr) ||
                       (newreq != 0 && m_pend[i] != 0 && cleared == 0)) ? 1 : 0;
            rem[i]  = (m_pend[i] != 0 && cleared == 0) ? 1 : 0;
        end
        if (m_valid == 0) begin
            s = search(m_pend, m_ptr);
            if (s >= 0) begin
                m_addr  = s;
                m_valid = 1;
            end
        end else if (hs != 0) begin
            m_ptr = (m_addr + 1) % N;
            s = search(rem, m_ptr);
            if (s >= 0) m_addr = s;
            else        m_valid = 0;
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = np[i];
            m_coll[i] = nc[i];
        end
    endtask

    function automatic logic [3:0] pack(input int bits [N]);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i] = (bits[i] != 0);
        return r;
    endfunction

    initial begin
        // {en, req, rdy, clr, exp valid, exp address, exp pending, exp collision}
        tbl[0]  = '{1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1011, 4'b0000};
        tbl[1]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b1011, 4'b0000};
        tbl[2]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1010, 4'b0000};
        tbl[3]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b0000};
        tbl[4]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
        tbl[5]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
        tbl[6]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0100, 4'b0000};
        tbl[7]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000};
        tbl[8]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
        tbl[9]  = '{1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0011, 4'b0000};
        tbl[10] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0011, 4'b0000};
        tbl[11] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000};
        tbl[12] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
        tbl[13] = '{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
        tbl[14] = '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 4'b0000};
        tbl[15] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000};
        tbl[16] = '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0001};
        tbl[17] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0000};
        tbl[18] = '{1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 4'b0000};
        tbl[19] = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000};
        tbl[20] = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0001};
        tbl[21] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000};

        // Reset held with all requests asserted.
        reset_n = 1'b0;
        drive(1'b1, 4'b1111, 1'b0, 1'b0);
        repeat (3) step();
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_address", 32'(bus.address), 32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        chk("rst_collision", 32'(bus.collision), 32'd0);
        drive(1'b1, 4'b0000, 1'b1, 1'b0);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("idle_valid", 32'(bus.valid), 32'd0);
            chk("idle_pending", 32'(bus.pending), 32'd0);
        end

        // Vector table: round-robin, single request, wrap, enable gating, collisions.
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].en, tbl[i].req, tbl[i].rdy, tbl[i].clr);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(bus.valid), 32'(tbl[i].v));
            if (tbl[i].v)
                chk($sformatf("vec%0d_address", i), 32'(bus.address), 32'(tbl[i].a));
            chk($sformatf("vec%0d_pending", i), 32'(bus.pending), 32'(tbl[i].pend));
            chk($sformatf("vec%0d_collision", i), 32'(bus.collision), 32'(tbl[i].coll));
        end

        // Backpressure: address 1 held while req[3] arrives, then drained 1,2,3.
        do_reset();
        drive(1'b1, 4'b0110, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, (c == 4) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
            step();
            chk("bp_valid", 32'(bus.valid), 32'd1);
            chk("bp_address", 32'(bus.address), 32'd1);
        end
        chk("bp_pending", 32'(bus.pending), 32'b1110);
        drive(1'b1, 4'b0000, 1'b1, 1'b0);
        step();
        chk("bp_drain2_valid", 32'(bus.valid), 32'd1);
        chk("bp_drain2_address", 32'(bus.address), 32'd2);
        step();
        chk("bp_drain3_valid", 32'(bus.valid), 32'd1);
        chk("bp_drain3_address", 32'(bus.address), 32'd3);
        step();
        chk("bp_done_valid", 32'(bus.valid), 32'd0);
        chk("bp_done_pending", 32'(bus.pending), 32'd0);

        // Async reset between edges while address 3 is presented.
        do_reset();
        drive(1'b1, 4'b1000, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        step();
        chk("ar_pre_valid", 32'(bus.valid), 32'd1);
        chk("ar_pre_address", 32'(bus.address), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.valid), 32'd0);
        chk("ar_address", 32'(bus.address), 32'd0);
        chk("ar_pending", 32'(bus.pending), 32'd0);
        chk("ar_collision", 32'(bus.collision), 32'd0);
        reset_n = 1'b1;
        step();
        chk("ar_after_valid", 32'(bus.valid), 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_coll[i] = 0;
        end
        m_ptr   = 0;
        m_valid = 0;
        m_addr  = 0;
        for (int c = 0; c < 1500; c++) begin
            logic       en;
            logic [3:0] rq;
            logic       rdy;
            logic       clr;
            en  = ($urandom_range(0, 9) != 0);
            rq  = 4'($urandom & $urandom);
            rdy = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 7) == 0);
            drive(en, rq, rdy, clr);
            model_edge(en, rq, rdy, clr);
            step();
            chk("rnd_valid", 32'(bus.valid), 32'(m_valid));
            if (m_valid != 0)
                chk("rnd_address", 32'(bus.address), 32'(m_addr));
            chk("rnd_pending", 32'(bus.pending), 32'(pack(m_pend)));
            chk("rnd_collision", 32'(bus.collision), 32'(pack(m_coll)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/request_encoder.md
Name: request_encoder

Overview:
- Reverse direction of the team's address decoder: collects N one-hot request lines and encodes them, one at a time, into a binary address with a valid/ready handshake.
- Requests are captured into a sticky pending register and granted in round-robin order.
- Sits between event sources (interrupt/request lines) and the address consumer that drives the decoder.

Parameters:
- N_LINES, 4, number of request lines (power of two, ≥2)
- ADDR_W, clog2(N_LINES) = 2, encoded address width

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  gates capture of new requests into pending
- req  input  N_LINES  request lines, sampled each clk edge (level; a held bit re-requests)
- out_ready  input  1  consumer accepts address this cycle
- address  output  ADDR_W  encoded index of granted line (registered)
- valid  output  1  address is valid (registered)
- pending  output  N_LINES  captured, not-yet-granted requests
- collision  output  N_LINES  sticky: request arrived on an already-pending line
- collision_clr  input  1  clears collision on next edge

Behaviour:
- Reset (async, reset_n=0): address=0, valid=0, pending=0, collision=0, rr pointer=0, state=IDLE; all take effect immediately, independent of clk.
- Capture: each edge, with enable=1, pending[i] <= 1 for every req[i]=1. With enable=0, req is ignored; a presentation already in progress continues.
- Grant selection (combinational on registered pending only): first set bit searching from pointer upward, wrapping at N_LINES-1 → 0.
- States: IDLE (valid=0), PRESENT (valid=1).
  - IDLE → PRESENT: pending≠0 at edge; address <= selected index. Latency: req high before edge k → pending at k → valid/address at k+1.
  - PRESENT, out_ready=0: address and valid held stable; new req bits only update pending.
  - PRESENT, out_ready=1 (handshake at edge): pending[address] cleared; pointer <= (address+1) mod N_LINES. If (pending & ~grant) ≠ 0, load next selection (searched from the new pointer) and stay in PRESENT: back-to-back, one grant per cycle. Otherwise → IDLE.
- Simultaneous events on line i at one edge:
  - req[i] and handshake clearing i: pending[i] stays 1 (new event); no collision.
  - req[i] with pending[i]=1 and no clear of i: collision[i] <= 1, pending unchanged.
  - collision_clr with a new collision: the new collision wins (bit stays 1).
- Lines whose requests arrive during the grant cycle are not selected in that same cycle; they are considered from the next edge on.
- Wrap: pointer wraps modulo N_LINES; the bit at pointer has highest priority.
- Reset mid-transfer: the presentation is aborted and pending is lost; the consumer sees valid drop asynchronously.

Decomposition:
- Shared package/include: state encoding (IDLE=0, PRESENT=1) and a clog2 constant function for ADDR_W.
- One sub-module, rr_priority_select: combinational. Inputs: pending and pointer. Outputs: index and found. Reusable by other arbiters.
- Top level holds the pending, collision, pointer, state and output registers.

Test Plan:
- Reset: hold reset_n=0, req=4'b1111 → valid=0, address=0, pending=0, collision=0. Release with req=0 → stays idle indefinitely.
- Single request: req=4'b0100 one cycle before edge 1, out_ready=1 → pending=0100 after edge 1; valid=1, address=2 after edge 2; after edge 3, valid=0 and pending=0.
- Round-robin back-to-back: pending=4'b1011, pointer=0, out_ready=1 → address 0,1,3 on consecutive cycles with valid continuous for 3 cycles, then valid=0 and pointer=0.
- Backpressure: pending=4'b0110, out_ready=0 for 10 cycles; req[3] pulses meanwhile → address stays 1 with valid=1 throughout; pending=1110. Raise out_ready → 1,2,3 in order.
- Collision: address=0 presented, out_ready=0, req=4'b0001 → collision=0001. Repeat with out_ready=1 at the same edge → collision stays 0, pending=0001, and address 0 is re-presented next cycle. collision_clr → collision=0.
- Async reset mid-operation: valid=1, address=3; drop reset_n between edges → valid=0, address=0, pending=0 before the next clk edge.
